// File: rtl/z80_arb_pkg.sv
// rtl/z80_arb_pkg.sv - shared types and sizing helpers for the Z80 bus arbiter
package z80_arb_pkg;

   typedef enum logic [1:0] {IDLE, REQ, GRANT, RELEASE} arb_state_t;

   localparam int MSEL_CPU = 0;

   function automatic int msel_width(input int qty);
      return $clog2(qty + 1);
   endfunction

   function automatic int idx_width(input int qty);
      return (qty > 1) ? $clog2(qty) : 1;
   endfunction

endpackage

// File: rtl/z80_arb_select.sv
// rtl/z80_arb_select.sv - combinational winner picker for the Z80 bus arbiter
// ARB_ROUND_ROBIN_EN selects rotating priority from ptr; otherwise lowest index wins.
module z80_arb_select
   import z80_arb_pkg::*;
#(
   parameter int REQ_QTY = 2,
   parameter int IW      = idx_width(REQ_QTY)
) (
   input  logic [REQ_QTY-1:0] req,
`ifdef ARB_ROUND_ROBIN_EN
   input  logic [IW-1:0]      ptr,
`endif
   output logic [IW-1:0]      idx,
   output logic               valid
);

`ifdef ARB_ROUND_ROBIN_EN
   always_comb begin
      int c;
      c     = 0;
      valid = 1'b0;
      idx   = '0;
      for (int k = 0; k < REQ_QTY; k++) begin
         c = int'(ptr) + k;
         if (c >= REQ_QTY) c = c - REQ_QTY;
         if (!valid && req[c]) begin
            valid = 1'b1;
            idx   = IW'(c);
         end
      end
   end
`else
   // Scanning downward lets the lowest asserted index overwrite the rest.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int k = REQ_QTY - 1; k >= 0; k--) begin
         if (req[k]) begin
            valid = 1'b1;
            idx   = IW'(k);
         end
      end
   end
`endif

endmodule

// File: rtl/z80_bus_arbiter.sv
// rtl/z80_bus_arbiter.sv - shares the Z80 bus between the CPU and secondary masters
// ARB_ROUND_ROBIN_EN enables round-robin winner selection (default: fixed priority).
module z80_bus_arbiter
   import z80_arb_pkg::*;
#(
   parameter int REQ_QTY  = 2,
   parameter int MAX_HOLD = 256
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [REQ_QTY-1:0]              req,
   output logic [REQ_QTY-1:0]              gnt,
   input  logic                            busak_n,
   output logic                            busrq_n,
   output logic [msel_width(REQ_QTY)-1:0]  msel,
   output logic                            cpu_owns,
   output logic                            preempt
);

   localparam int MW = msel_width(REQ_QTY);
   localparam int IW = idx_width(REQ_QTY);
   localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
   localparam logic [MW-1:0] MSEL_IDLE = MW'(MSEL_CPU);

   arb_state_t          state, state_nxt;
   logic [IW-1:0]       win, win_nxt;
   logic [HW-1:0]       cnt, cnt_nxt;
   logic                drain, drain_nxt;
   logic [REQ_QTY-1:0]  gnt_nxt;
   logic [MW-1:0]       msel_nxt;
   logic                busrq_n_nxt, cpu_owns_nxt, preempt_nxt;
   logic [IW-1:0]       sel_idx;
   logic                sel_valid;

`ifdef ARB_ROUND_ROBIN_EN
   logic [IW-1:0]       ptr, ptr_nxt;
`endif

   z80_arb_select #(.REQ_QTY(REQ_QTY), .IW(IW)) u_select (
      .req   (req),
`ifdef ARB_ROUND_ROBIN_EN
      .ptr   (ptr),
`endif
      .idx   (sel_idx),
      .valid (sel_valid)
   );

   always_comb begin
      state_nxt   = state;
      win_nxt     = win;
      cnt_nxt     = cnt;
      drain_nxt   = 1'b0;
      gnt_nxt     = gnt;
      msel_nxt    = msel;
      busrq_n_nxt = busrq_n;
      preempt_nxt = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_nxt     = ptr;
`endif
      case (state)
         IDLE: begin
            gnt_nxt     = '0;
            msel_nxt    = MSEL_IDLE;
            busrq_n_nxt = 1'b1;
            if (sel_valid) begin
               state_nxt   = REQ;
               win_nxt     = sel_idx;
               busrq_n_nxt = 1'b0;
            end
         end
         REQ: begin
            busrq_n_nxt = 1'b0;
            if (!busak_n) begin
               if (req[win]) begin
                  state_nxt = GRANT;
                  gnt_nxt   = REQ_QTY'(1) << win;
                  msel_nxt  = MW'(win) + MW'(1);
                  cnt_nxt   = '0;
`ifdef ARB_ROUND_ROBIN_EN
                  ptr_nxt   = (win == IW'(REQ_QTY - 1)) ? '0 : win + 1'b1;
`endif
               end else begin
                  state_nxt = RELEASE;
                  drain_nxt = 1'b1;
               end
            end
         end
         GRANT: begin
            if (busak_n || !req[win]) begin
               state_nxt = RELEASE;
               gnt_nxt   = '0;
               drain_nxt = 1'b1;
            end else if (MAX_HOLD != 0 && cnt == HOLD_LAST) begin
               state_nxt   = RELEASE;
               gnt_nxt     = '0;
               drain_nxt   = 1'b1;
               preempt_nxt = 1'b1;
            end else if (cnt != '1) begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         RELEASE: begin
            // The drain cycle keeps msel on the old master; the CPU gets
            // busrq_n high before the arbiter may return to IDLE.
            gnt_nxt     = '0;
            msel_nxt    = MSEL_IDLE;
            busrq_n_nxt = 1'b1;
            if (!drain && busak_n) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      cpu_owns_nxt = (msel_nxt == MSEL_IDLE) && busak_n;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         win      <= '0;
         cnt      <= '0;
         drain    <= 1'b0;
         gnt      <= '0;
         msel     <= MSEL_IDLE;
         busrq_n  <= 1'b1;
         cpu_owns <= 1'b1;
         preempt  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         ptr      <= '0;
`endif
      end else begin
         state    <= state_nxt;
         win      <= win_nxt;
         cnt      <= cnt_nxt;
         drain    <= drain_nxt;
         gnt      <= gnt_nxt;
         msel     <= msel_nxt;
         busrq_n  <= busrq_n_nxt;
         cpu_owns <= cpu_owns_nxt;
         preempt  <= preempt_nxt;
`ifdef ARB_ROUND_ROBIN_EN
         ptr      <= ptr_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// tb/tb_z80_bus_arbiter.sv - self-checking bench for z80_bus_arbiter (REQ_QTY=2, MAX_HOLD=4)
module tb_z80_bus_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] req = 2'b00;
   logic       busak_n = 1'b1;
   logic [1:0] gnt;
   logic       busrq_n;
   logic [1:0] msel;
   logic       cpu_owns;
   logic       preempt;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic       rst;
      logic [1:0] req;
      logic       busak_n;
      logic [6:0] exp;   // {gnt, msel, busrq_n, cpu_owns, preempt}
   } vec_t;

   vec_t       vecs[$];
   logic [1:0] grants[$];
   int         runs[$];
   int         pre_cnt;
   int         viol;

   z80_bus_arbiter #(.REQ_QTY(2), .MAX_HOLD(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .gnt      (gnt),
      .busak_n  (busak_n),
      .busrq_n  (busrq_n),
      .msel     (msel),
      .cpu_owns (cpu_owns),
      .preempt  (preempt)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [1:0] q, input logic ak,
                      input logic [1:0] g, input logic [1:0] m,
                      input logic brq, input logic co, input logic pe);
      vec_t v;
      v.rst = r; v.req = q; v.busak_n = ak;
      v.exp = {g, m, brq, co, pe};
      vecs.push_back(v);
   endtask

   task automatic do_reset();
      rst = 1'b1; req = 2'b00; busak_n = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // CPU model: busak_n follows busrq_n one cycle later.
   task automatic run_held(input logic [1:0] r, input int cycles);
      int         run;
      logic       brq_hi;
      logic [1:0] pg;
      logic       pp;
      run = 0; brq_hi = 1'b1; pg = 2'b00; pp = 1'b0;
      grants.delete(); runs.delete(); pre_cnt = 0; viol = 0;
      do_reset();
      req = r;
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk); #1;
         if (gnt != 2'b00 && pg == 2'b00) begin
            grants.push_back(gnt);
            if (!brq_hi) viol++;
            brq_hi = 1'b0;
         end
         if (gnt != 2'b00) run++;
         else if (pg != 2'b00) begin
            runs.push_back(run);
            run = 0;
         end
         if (gnt == 2'b00 && busrq_n) brq_hi = 1'b1;
         if (preempt) pre_cnt++;
         if (preempt && pp) viol++;
         if (gnt == 2'b01 && msel != 2'd1) viol++;
         if (gnt == 2'b10 && msel != 2'd2) viol++;
         if (gnt == 2'b11 || (gnt != 2'b00 && cpu_owns)) viol++;
         if (msel != 2'd0 && busak_n) viol++;
         pg = gnt; pp = preempt;
         busak_n = busrq_n;
      end
      req = 2'b00;
   endtask

   initial begin
      int bad_runs;
      // rst, req, busak_n  ->  gnt, msel, busrq_n, cpu_owns, preempt
      add(1, 2'b00, 1, 2'b00, 2'd0, 1, 1, 0);   // reset state
      add(0, 2'b01, 1, 2'b00, 2'd0, 0, 1, 0);   // basic grant: busrq_n falls
      add(0, 2'b01, 1, 2'b00, 2'd0, 0, 1, 0);
      add(0, 2'b01, 1, 2'b00, 2'd0, 0, 1, 0);
      add(0, 2'b01, 0, 2'b01, 2'd1, 0, 0, 0);   // busak_n low sampled: grant
      add(0, 2'b01, 0, 2'b01, 2'd1, 0, 0, 0);
      add(0, 2'b00, 0, 2'b00, 2'd1, 0, 0, 0);   // req drop: gnt off, drain
      add(0, 2'b00, 0, 2'b00, 2'd0, 1, 0, 0);   // msel back to CPU
      add(0, 2'b00, 0, 2'b00, 2'd0, 1, 0, 0);
      add(0, 2'b00, 1, 2'b00, 2'd0, 1, 1, 0);   // back to IDLE
      add(0, 2'b00, 1, 2'b00, 2'd0, 1, 1, 0);
      add(0, 2'b10, 1, 2'b00, 2'd0, 0, 1, 0);   // requester 1
      add(0, 2'b10, 0, 2'b10, 2'd2, 0, 0, 0);
      add(0, 2'b00, 0, 2'b00, 2'd2, 0, 0, 0);
      add(0, 2'b00, 0, 2'b00, 2'd0, 1, 0, 0);
      add(0, 2'b00, 1, 2'b00, 2'd0, 1, 1, 0);
      add(0, 2'b01, 1, 2'b00, 2'd0, 0, 1, 0);   // withdrawn during REQ
      add(0, 2'b00, 0, 2'b00, 2'd0, 0, 0, 0);
      add(0, 2'b00, 0, 2'b00, 2'd0, 1, 0, 0);
      add(0, 2'b00, 1, 2'b00, 2'd0, 1, 1, 0);
      add(0, 2'b00, 1, 2'b00, 2'd0, 1, 1, 0);
      add(0, 2'b01, 1, 2'b00, 2'd0, 0, 1, 0);   // reset in GRANT
      add(0, 2'b01, 0, 2'b01, 2'd1, 0, 0, 0);
      add(1, 2'b01, 0, 2'b00, 2'd0, 1, 1, 0);
      add(0, 2'b00, 1, 2'b00, 2'd0, 1, 1, 0);
      add(0, 2'b01, 1, 2'b00, 2'd0, 0, 1, 0);   // busak_n forced high in GRANT
      add(0, 2'b01, 0, 2'b01, 2'd1, 0, 0, 0);
      add(0, 2'b01, 1, 2'b00, 2'd1, 0, 0, 0);
      add(0, 2'b01, 1, 2'b00, 2'd0, 1, 1, 0);
      add(0, 2'b01, 1, 2'b00, 2'd0, 1, 1, 0);
      add(0, 2'b01, 1, 2'b00, 2'd0, 0, 1, 0);   // IDLE reached, new REQ
      add(0, 2'b00, 0, 2'b00, 2'd0, 0, 0, 0);
      add(0, 2'b00, 0, 2'b00, 2'd0, 1, 0, 0);
      add(0, 2'b00, 1, 2'b00, 2'd0, 1, 1, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst; req = vecs[i].req; busak_n = vecs[i].busak_n;
         @(posedge clk); #1;
         check($sformatf("vec%0d", i), {25'd0, gnt, msel, busrq_n, cpu_owns, preempt}, {25'd0, vecs[i].exp});
      end
      rst = 1'b0;

      // Simultaneous requests held: every tenure is cut at MAX_HOLD.
      run_held(2'b11, 40);
      check("both_grant_count_ge3", 32'(grants.size() >= 3), 32'd1);
      check("both_grant0", 32'((grants.size() > 0) ? grants[0] : 2'b00), 32'h1);
`ifdef ARB_ROUND_ROBIN_EN
      check("both_grant1", 32'((grants.size() > 1) ? grants[1] : 2'b00), 32'h2);
`else
      check("both_grant1", 32'((grants.size() > 1) ? grants[1] : 2'b00), 32'h1);
`endif
      check("both_grant2", 32'((grants.size() > 2) ? grants[2] : 2'b00), 32'h1);
      bad_runs = 0;
      foreach (runs[k]) if (runs[k] != 4) bad_runs++;
      check("both_run_len_4", 32'(bad_runs), 32'd0);
      check("both_preempt_per_run", 32'(pre_cnt), 32'(runs.size()));
      check("both_invariants", 32'(viol), 32'd0);

      // Single requester held: preempted then re-granted.
      run_held(2'b01, 30);
      check("hold_regrant", 32'(grants.size() >= 2), 32'd1);
      check("hold_first_run", 32'((runs.size() > 0) ? runs[0] : 0), 32'd4);
      check("hold_preempt_seen", 32'(pre_cnt >= 1), 32'd1);
      check("hold_preempt_per_run", 32'(pre_cnt), 32'(runs.size()));
      bad_runs = 0;
      foreach (grants[k]) if (grants[k] != 2'b01) bad_runs++;
      check("hold_grant_is_01", 32'(bad_runs), 32'd0);
      check("hold_invariants", 32'(viol), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
